audio_sample_pacer: RTL and testbench

//  Upstream pacing stage for sigma_delta_dac: buffers PCM codes arriving by valid/ready

---
 rtl/audio_sample_pacer.sv | 129 ++++++++++++
 tb/tb_audio_sample_pacer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_pacer.sv
// rtl/audio_sample_pacer.sv - FIFO-buffered PCM pacer releasing one held code per sample period
module audio_sample_pacer #(
  parameter int CODE_WIDTH      = 10,
  parameter int DEPTH           = 8,
  parameter int CLKS_PER_SAMPLE = 2500
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [CODE_WIDTH-1:0]    sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  output logic [CODE_WIDTH-1:0]    code,
  output logic                     sample_tick,
  output logic                     underflow,
  input  logic                     underflow_clr,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;

  localparam logic [CODE_WIDTH-1:0] MID  = {1'b1, {(CODE_WIDTH-1){1'b0}}};
  localparam logic [PW:0]           FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]           HALF = (PW+1)'(DEPTH / 2);
  localparam logic [CNTW-1:0]       LAST = CNTW'(CLKS_PER_SAMPLE - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                  state_q, state_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW:0]             count_q, count_d;
  logic [CODE_WIDTH-1:0]   code_q, code_d;
  logic                    tick_q, tick_d;
  logic                    underflow_q, underflow_d;
  logic [CODE_WIDTH-1:0]   mem_q [DEPTH];

  logic flush, tick, push, pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      code_q      <= MID;
      tick_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      code_q      <= code_d;
      tick_q      <= tick_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = PRIME;
      PRIME:   if (!enable) state_d = IDLE;
               else if (count_q >= HALF) state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // Leaving PRIME/RUN wins over any tick or push in the same cycle.
    flush = (state_q != IDLE) && !enable;
    tick  = (state_q == RUN) && enable && (cnt_q == LAST);
    push  = sample_valid && (count_q != FULL) && !flush;
    pop   = tick && (count_q != '0);

    cnt_d = ((state_q == RUN) && enable && (cnt_q != LAST)) ? cnt_q + CNTW'(1) : '0;

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    code_d = code_q;
    if (flush || (state_q != RUN)) begin
      code_d = MID;
    end else if (pop) begin
      code_d = mem_q[rd_ptr_q];
    end

    tick_d = tick;

    // A set in the same cycle as a clear takes priority.
    underflow_d = underflow_q;
    if (tick && (count_q == '0)) begin
      underflow_d = 1'b1;
    end else if (underflow_clr) begin
      underflow_d = 1'b0;
    end
  end

  assign sample_ready = (count_q != FULL);
  assign code         = code_q;
  assign sample_tick  = tick_q;
  assign underflow    = underflow_q;
  assign fifo_count   = count_q;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// tb/tb_audio_sample_pacer.sv - scoreboard bench for audio_sample_pacer (DEPTH=4, 4 clks/sample)
module tb_audio_sample_pacer;

  localparam int CW  = 10;
  localparam int DP  = 4;
  localparam int CPS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [CW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic [CW-1:0] code;
  logic          sample_tick;
  logic          underflow;
  logic          underflow_clr;
  logic [2:0]    fifo_count;

  audio_sample_pacer #(.CODE_WIDTH(CW), .DEPTH(DP), .CLKS_PER_SAMPLE(CPS)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .code         (code),
    .sample_tick  (sample_tick),
    .underflow    (underflow),
    .underflow_clr(underflow_clr),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int uf;
    bit gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_tick = 0;
  exp_t e;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_tick(input int c, input int uf, input bit gap);
    exp_t x;
    x.code = c;
    x.uf   = uf;
    x.gap  = gap;
    exp_q.push_back(x);
  endtask

  // Every observed tick must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && sample_tick) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: got code %0d, expected no tick (cycle %0d)", code, cyc);
      end else begin
        e = exp_q.pop_front();
        check("tick_code", int'(code), e.code);
        check("tick_underflow", int'(underflow), e.uf);
        if (e.gap) check("tick_spacing", cyc - last_tick, CPS);
      end
      last_tick = cyc;
    end
  end

  task automatic push(input int v);
    sample_in    = CW'(v);
    sample_valid = 1'b1;
    check("ready_at_push", int'(sample_ready), 1);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (sample_tick) seen = 1'b1;
    end
    if (!seen) check("tick_timeout", 0, 1);
  endtask

  initial begin
    rst           = 1'b1;
    enable        = 1'b0;
    sample_in     = '0;
    sample_valid  = 1'b0;
    underflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state, and idle hold with no ticks
    check("reset_code", int'(code), 512);
    check("reset_ready", int'(sample_ready), 1);
    check("reset_count", int'(fifo_count), 0);
    check("reset_underflow", int'(underflow), 0);
    repeat (20) @(negedge clk);
    check("idle_code", int'(code), 512);

    // Prime and run, then drain into underflow
    expect_tick(100, 0, 1'b0);
    expect_tick(200, 0, 1'b1);
    expect_tick(300, 0, 1'b1);
    expect_tick(400, 0, 1'b1);
    expect_tick(400, 1, 1'b1);
    expect_tick(400, 1, 1'b1);
    enable = 1'b1;
    push(100);
    push(200);
    push(300);
    push(400);
    repeat (5) wait_tick();
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    check("underflow_cleared", int'(underflow), 0);
    check("code_held_after_underflow", int'(code), 400);
    wait_tick();
    enable = 1'b0;
    @(negedge clk);
    check("disable_code", int'(code), 512);
    check("disable_count", int'(fifo_count), 0);
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;

    // Back-to-back pushes while idle: fifth is held off
    for (int i = 0; i < 5; i++) begin
      sample_in    = CW'(11 + i);
      sample_valid = 1'b1;
      check("ready_fill", int'(sample_ready), (i < 4) ? 1 : 0);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    check("full_count", int'(fifo_count), 4);
    check("full_ready", int'(sample_ready), 0);

    // Disable exactly on a tick cycle with three entries left
    expect_tick(11, 0, 1'b0);
    enable = 1'b1;
    wait_tick();
    repeat (3) @(negedge clk);
    check("count_before_disable", int'(fifo_count), 3);
    enable = 1'b0;
    @(negedge clk);
    check("flush_count", int'(fifo_count), 0);
    check("flush_code", int'(code), 512);
    check("flush_no_tick", int'(sample_tick), 0);

    // Push coinciding with a pop at count DEPTH-1
    expect_tick(1, 0, 1'b0);
    enable = 1'b1;
    push(1);
    push(2);
    push(3);
    push(4);
    wait_tick();
    check("count_after_first_pop", int'(fifo_count), 3);
    for (int k = 0; k < 4; k++) begin
      expect_tick(k + 2, 0, 1'b1);
      repeat (3) @(negedge clk);
      sample_in    = CW'(5 + k);
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      check("pushpop_tick", int'(sample_tick), 1);
      check("pushpop_count", int'(fifo_count), 3);
    end
    enable = 1'b0;
    @(negedge clk);
    check("final_flush_count", int'(fifo_count), 0);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
